// File: rtl/console_pkg.sv
// rtl/console_pkg.sv - shared types, control codes and cell/address helpers for console_ctrl
package console_pkg;

    typedef enum logic [1:0] {
        CLR_ALL,
        IDLE,
        SCROLL_CLR
    } state_t;

    localparam logic [7:0] ASC_BS    = 8'h08;
    localparam logic [7:0] ASC_LF    = 8'h0A;
    localparam logic [7:0] ASC_FF    = 8'h0C;
    localparam logic [7:0] ASC_CR    = 8'h0D;
    localparam logic [7:0] ASC_SPACE = 8'h20;

    function automatic logic [31:0] pack_cell(input logic [11:0] fg,
                                              input logic [11:0] bg,
                                              input logic [7:0]  ch);
        return {fg, bg, ch};
    endfunction

    function automatic logic [11:0] cell_addr(input logic [6:0] h,
                                              input logic [4:0] phys_v);
        return {h, phys_v};
    endfunction

endpackage

// File: rtl/console_ctrl.sv
// rtl/console_ctrl.sv - text console engine driving the char_buf write port and scroll offset
module console_ctrl
    import console_pkg::*;
#(
    parameter int          COLS     = 70,
    parameter int          ROWS     = 30,
    parameter logic [11:0] FG_COLOR = 12'hFFF,
    parameter logic [11:0] BG_COLOR = 12'h000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cmd_valid,
    input  logic [7:0]  cmd_char,
    output logic        cmd_ready,
    output logic        buf_we,
    output logic [11:0] buf_addr,
    output logic [31:0] buf_data,
    output logic [6:0]  cur_h,
    output logic [4:0]  cur_v,
    output logic [4:0]  line_offset
);

    localparam logic [6:0]  H_LAST = 7'(COLS - 1);
    localparam logic [4:0]  V_LAST = 5'(ROWS - 1);
    localparam logic [31:0] BLANK  = pack_cell(FG_COLOR, BG_COLOR, ASC_SPACE);

    state_t     state;
    logic [6:0] clr_h;
    logic [4:0] clr_v;

    logic       accept;
    logic       is_print;
    logic       is_eol;
    logic       do_nl;
    logic [4:0] phys_v;
    logic [4:0] phys_up;
    logic [4:0] scroll_row;

    assign cmd_ready = (state == IDLE);

    always_comb begin
        accept     = cmd_valid && (state == IDLE);
        is_print   = (cmd_char >= 8'h20) && (cmd_char <= 8'h7E);
        is_eol     = (cmd_char == ASC_LF) || (cmd_char == ASC_CR);
        do_nl      = accept && ((is_print && cur_h == H_LAST) || is_eol);
        phys_v     = cur_v + line_offset;
        // row above the cursor in physical space, wrapping like the display does
        phys_up    = phys_v - 5'd1;
        scroll_row = V_LAST + line_offset;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= CLR_ALL;
            clr_h       <= '0;
            clr_v       <= '0;
            cur_h       <= '0;
            cur_v       <= '0;
            line_offset <= '0;
            buf_we      <= 1'b0;
            buf_addr    <= '0;
            buf_data    <= '0;
        end else begin
            buf_we <= 1'b0;
            case (state)
                CLR_ALL: begin
                    buf_we   <= 1'b1;
                    buf_addr <= cell_addr(clr_h, clr_v);
                    buf_data <= BLANK;
                    if (clr_h == H_LAST) begin
                        clr_h <= '0;
                        clr_v <= clr_v + 5'd1;
                        if (clr_v == 5'd31) begin
                            state       <= IDLE;
                            cur_h       <= '0;
                            cur_v       <= '0;
                            line_offset <= '0;
                        end
                    end else begin
                        clr_h <= clr_h + 7'd1;
                    end
                end

                IDLE: begin
                    if (accept) begin
                        if (is_print) begin
                            buf_we   <= 1'b1;
                            buf_addr <= cell_addr(cur_h, phys_v);
                            buf_data <= pack_cell(FG_COLOR, BG_COLOR, cmd_char);
                            cur_h    <= (cur_h < H_LAST) ? cur_h + 7'd1 : 7'd0;
                        end else if (is_eol) begin
                            cur_h <= '0;
                        end else if (cmd_char == ASC_BS) begin
                            if (cur_h != 7'd0) begin
                                cur_h    <= cur_h - 7'd1;
                                buf_we   <= 1'b1;
                                buf_addr <= cell_addr(cur_h - 7'd1, phys_v);
                                buf_data <= BLANK;
                            end else if (cur_v != 5'd0) begin
                                cur_h    <= H_LAST;
                                cur_v    <= cur_v - 5'd1;
                                buf_we   <= 1'b1;
                                buf_addr <= cell_addr(H_LAST, phys_up);
                                buf_data <= BLANK;
                            end
                        end else if (cmd_char == ASC_FF) begin
                            state <= CLR_ALL;
                        end
                    end
                    if (do_nl) begin
                        if (cur_v < V_LAST) begin
                            cur_v <= cur_v + 5'd1;
                        end else begin
                            line_offset <= line_offset + 5'd1;
                            state       <= SCROLL_CLR;
                        end
                    end
                end

                SCROLL_CLR: begin
                    // line_offset already advanced, so scroll_row is the newly exposed bottom row
                    buf_we   <= 1'b1;
                    buf_addr <= cell_addr(clr_h, scroll_row);
                    buf_data <= BLANK;
                    if (clr_h == H_LAST) begin
                        clr_h <= '0;
                        state <= IDLE;
                    end else begin
                        clr_h <= clr_h + 7'd1;
                    end
                end

                default: state <= CLR_ALL;
            endcase
        end
    end

endmodule

// File: tb/tb_console_ctrl.sv
// tb/tb_console_ctrl.sv - directed self-checking bench for console_ctrl
module tb_console_ctrl;

    localparam logic [31:0] BLANK = 32'hFFF00020;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        cmd_valid = 1'b0;
    logic [7:0]  cmd_char = 8'h00;
    logic        cmd_ready;
    logic        buf_we;
    logic [11:0] buf_addr;
    logic [31:0] buf_data;
    logic [6:0]  cur_h;
    logic [4:0]  cur_v;
    logic [4:0]  line_offset;

    int errors = 0;
    int checks = 0;

    logic [11:0] wa_q[$];
    logic [31:0] wd_q[$];

    always #5 clock = ~clock;

    console_ctrl dut (
        .clock       (clock),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_char    (cmd_char),
        .cmd_ready   (cmd_ready),
        .buf_we      (buf_we),
        .buf_addr    (buf_addr),
        .buf_data    (buf_data),
        .cur_h       (cur_h),
        .cur_v       (cur_v),
        .line_offset (line_offset)
    );

    always @(posedge clock) begin
        #1;
        if (buf_we === 1'b1) begin
            wa_q.push_back(buf_addr);
            wd_q.push_back(buf_data);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_log();
        wa_q.delete();
        wd_q.delete();
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (cmd_ready !== 1'b1 && n < 5000) begin
            @(negedge clock);
            n++;
        end
    endtask

    task automatic send(input logic [7:0] ch);
        int n;
        wait_idle(n);
        if (cmd_ready !== 1'b1) check_eq("send_timeout", 32'd0, 32'd1);
        cmd_valid = 1'b1;
        cmd_char  = ch;
        @(negedge clock);
        cmd_valid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_ready"}, 32'(cmd_ready), 32'd0);
        check_eq({tag, "_we"},    32'(buf_we), 32'd0);
        check_eq({tag, "_addr"},  32'(buf_addr), 32'd0);
        check_eq({tag, "_data"},  buf_data, 32'd0);
        check_eq({tag, "_h"},     32'(cur_h), 32'd0);
        check_eq({tag, "_v"},     32'(cur_v), 32'd0);
        check_eq({tag, "_off"},   32'(line_offset), 32'd0);
    endtask

    // expects the full-screen clear: rows 0..31 outer, columns 0..69 inner, all blank
    task automatic check_full_clear(input string tag);
        int bad = 0;
        logic [6:0] h;
        logic [4:0] v;
        for (int i = 0; i < wa_q.size(); i++) begin
            h = 7'(i % 70);
            v = 5'(i / 70);
            if (wa_q[i] !== {h, v} || wd_q[i] !== BLANK) bad++;
        end
        check_eq({tag, "_count"}, 32'(wa_q.size()), 32'd2240);
        check_eq({tag, "_order"}, 32'(bad), 32'd0);
    endtask

    task automatic check_row_clear(input string tag, input int first, input logic [4:0] row);
        int bad = 0;
        for (int i = 0; i < 70; i++) begin
            if (first + i >= wa_q.size()) bad++;
            else if (wa_q[first + i] !== {7'(i), row} || wd_q[first + i] !== BLANK) bad++;
        end
        check_eq({tag, "_rowclr"}, 32'(bad), 32'd0);
    endtask

    initial begin
        int  n;
        logic rdy_all;

        repeat (3) @(negedge clock);
        check_reset_outputs("reset");

        reset = 1'b1;
        wait_idle(n);
        check_eq("init_ready_delay", 32'(n), 32'd2240);
        @(negedge clock);
        check_full_clear("init");
        check_eq("init_h", 32'(cur_h), 32'd0);
        check_eq("init_v", 32'(cur_v), 32'd0);
        check_eq("init_off", 32'(line_offset), 32'd0);
        clear_log();

        cmd_valid = 1'b1;
        cmd_char  = 8'h41;
        rdy_all   = cmd_ready;
        @(negedge clock);
        rdy_all   = rdy_all & cmd_ready;
        cmd_char  = 8'h42;
        @(negedge clock);
        rdy_all   = rdy_all & cmd_ready;
        cmd_valid = 1'b0;
        @(negedge clock);
        check_eq("b2b_count", 32'(wa_q.size()), 32'd2);
        check_eq("b2b_addr0", 32'(wa_q[0]), 32'h000);
        check_eq("b2b_data0", wd_q[0], 32'hFFF00041);
        check_eq("b2b_addr1", 32'(wa_q[1]), 32'h020);
        check_eq("b2b_data1", wd_q[1], 32'hFFF00042);
        check_eq("b2b_h", 32'(cur_h), 32'd2);
        check_eq("b2b_ready", 32'(rdy_all), 32'd1);

        repeat (29) send(8'h0A);
        repeat (69) send(8'h78);
        check_eq("pos_h", 32'(cur_h), 32'd69);
        check_eq("pos_v", 32'(cur_v), 32'd29);
        clear_log();
        send(8'h5A);
        wait_idle(n);
        check_eq("scroll_busy", 32'(n), 32'd70);
        @(negedge clock);
        check_eq("scroll_count", 32'(wa_q.size()), 32'd71);
        check_eq("scroll_char_addr", 32'(wa_q[0]), 32'h8BD);
        check_eq("scroll_char_data", wd_q[0], 32'hFFF0005A);
        check_row_clear("scroll", 1, 5'd30);
        check_eq("scroll_off", 32'(line_offset), 32'd1);
        check_eq("scroll_h", 32'(cur_h), 32'd0);
        check_eq("scroll_v", 32'(cur_v), 32'd29);

        repeat (30) send(8'h0A);
        wait_idle(n);
        check_eq("pre_wrap_off", 32'(line_offset), 32'd31);
        clear_log();
        send(8'h0A);
        wait_idle(n);
        @(negedge clock);
        check_eq("wrap_off", 32'(line_offset), 32'd0);
        check_eq("wrap_count", 32'(wa_q.size()), 32'd70);
        check_row_clear("wrap", 0, 5'd29);
        check_eq("wrap_v", 32'(cur_v), 32'd29);

        clear_log();
        send(8'h0C);
        wait_idle(n);
        @(negedge clock);
        check_full_clear("ff");
        check_eq("ff_v", 32'(cur_v), 32'd0);

        repeat (5) send(8'h0A);
        clear_log();
        send(8'h08);
        repeat (2) @(negedge clock);
        check_eq("bs_count", 32'(wa_q.size()), 32'd1);
        check_eq("bs_addr", 32'(wa_q[0]), 32'h8A4);
        check_eq("bs_data", wd_q[0], BLANK);
        check_eq("bs_h", 32'(cur_h), 32'd69);
        check_eq("bs_v", 32'(cur_v), 32'd4);

        send(8'h0C);
        wait_idle(n);
        @(negedge clock);
        clear_log();
        send(8'h08);
        repeat (3) @(negedge clock);
        check_eq("bs00_count", 32'(wa_q.size()), 32'd0);
        check_eq("bs00_h", 32'(cur_h), 32'd0);
        check_eq("bs00_v", 32'(cur_v), 32'd0);

        repeat (29) send(8'h0A);
        clear_log();
        send(8'h0A);
        n = 0;
        while (wa_q.size() < 10 && n < 100) begin
            @(negedge clock);
            n++;
        end
        check_eq("midclr_count", 32'(wa_q.size()), 32'd10);
        check_eq("midclr_addr0", 32'(wa_q[0]), 32'h01E);
        reset = 1'b0;
        #1;
        check_reset_outputs("midrst");
        @(negedge clock);
        reset = 1'b1;
        clear_log();
        wait_idle(n);
        check_eq("rst_ready_delay", 32'(n), 32'd2240);
        @(negedge clock);
        check_full_clear("rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
